// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode/funct constants and control field codes shared by the controller.
package ctrl_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MADDR, S_MREAD, S_MWB, S_MWRITE, S_EXEC, S_RWB, S_BRANCH, S_JUMP
   } state_t;
   typedef enum logic [2:0] {C_ILL, C_LOAD, C_STORE, C_RTYPE, C_ITYPE, C_BRANCH, C_JUMP} cls_t;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08, F_JALR = 6'h09;
   localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV = 6'h1A, F_DIVU = 6'h1B, F_ADD = 6'h20, F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10;
   localparam logic [2:0] J_SEQ = 3'd0, J_BR = 3'd1, J_IDX = 3'd2, J_REG = 3'd3;
   localparam logic [2:0] M2R_ALU = 3'd0, M2R_MEM = 3'd1, M2R_PC4 = 3'd2, M2R_HI = 3'd3, M2R_LO = 3'd4;
   localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
   localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
   localparam logic [2:0] BR_EQ = 3'd0, BR_NE = 3'd1, BR_GTZ = 3'd2, BR_LEZ = 3'd3, BR_GEZ = 3'd4, BR_LTZ = 3'd5;
   // compare is {zero, more, notless}
   function automatic logic br_taken(logic [2:0] brk, logic [2:0] cmp);
      return brk == BR_EQ ? cmp[2] : brk == BR_NE ? !cmp[2] : brk == BR_GTZ ? cmp[1] :
             brk == BR_LEZ ? !cmp[1] : brk == BR_GEZ ? cmp[0] : !cmp[0];
   endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction classifier producing class, ALU/extend codes and writeback details.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  cls,
   output logic [3:0]  aluop,
   output logic [1:0]  extop,
   output logic        imm,
   output logic        wb,
   output logic [1:0]  dst,
   output logic [2:0]  wbsel,
   output logic [2:0]  jsel,
   output logic [2:0]  brk
);
   logic [5:0] op, fn;
   logic [4:0] rt;
   logic unused_bits;
   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign rt = instr[20:16];
   assign unused_bits = ^{instr[25:21], instr[15:6]};
   always_comb begin
      cls = C_ILL;
      aluop = ALU_ADD;
      extop = EXT_SIGN;
      imm = 1'b0;
      wb = 1'b1;
      dst = RD_RD;
      wbsel = M2R_ALU;
      jsel = J_SEQ;
      brk = BR_EQ;
      case (op)
         OP_RTYPE: begin
            cls = C_RTYPE;
            case (fn)
               F_SLL: aluop = ALU_SLL;
               F_SRL: aluop = ALU_SRL;
               F_SRA: aluop = ALU_SRA;
               F_ADD, F_ADDU: aluop = ALU_ADD;
               F_SUB, F_SUBU: aluop = ALU_SUB;
               F_AND: aluop = ALU_AND;
               F_OR: aluop = ALU_OR;
               F_XOR: aluop = ALU_XOR;
               F_NOR: aluop = ALU_NOR;
               F_SLT: aluop = ALU_SLT;
               F_SLTU: aluop = ALU_SLTU;
               F_MFHI: wbsel = M2R_HI;
               F_MFLO: wbsel = M2R_LO;
               F_MULT, F_MULTU, F_DIV, F_DIVU: wb = 1'b0;
               F_JR: begin cls = C_JUMP; jsel = J_REG; wb = 1'b0; end
               F_JALR: begin cls = C_JUMP; jsel = J_REG; wbsel = M2R_PC4; end
               default: cls = C_ILL;
            endcase
         end
         OP_REGIMM: begin
            cls = rt == 5'd0 || rt == 5'd1 ? C_BRANCH : C_ILL;
            brk = rt == 5'd0 ? BR_LTZ : BR_GEZ;
         end
         OP_J: begin cls = C_JUMP; jsel = J_IDX; wb = 1'b0; end
         OP_JAL: begin cls = C_JUMP; jsel = J_IDX; dst = RD_RA; wbsel = M2R_PC4; end
         OP_BEQ: begin cls = C_BRANCH; brk = BR_EQ; end
         OP_BNE: begin cls = C_BRANCH; brk = BR_NE; end
         OP_BLEZ: begin cls = C_BRANCH; brk = BR_LEZ; end
         OP_BGTZ: begin cls = C_BRANCH; brk = BR_GTZ; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            cls = C_ITYPE;
            imm = 1'b1;
            dst = RD_RT;
            aluop = op == OP_SLTI ? ALU_SLT : op == OP_SLTIU ? ALU_SLTU : op == OP_ANDI ? ALU_AND :
                    op == OP_ORI ? ALU_OR : op == OP_XORI ? ALU_XOR : ALU_ADD;
            extop = op == OP_ANDI || op == OP_ORI || op == OP_XORI ? EXT_ZERO : op == OP_LUI ? EXT_LUI : EXT_SIGN;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin cls = C_LOAD; dst = RD_RT; wbsel = M2R_MEM; end
         OP_SB, OP_SH, OP_SW: begin cls = C_STORE; wb = 1'b0; dst = RD_RT; end
         default: cls = C_ILL;
      endcase
   end
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle MIPS-style control FSM; outputs are decoded from the state register and instr.
module ctrl_fsm
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [2:0]  compare,
   output logic        PCWr,
   output logic        IRWr,
   output logic [1:0]  regdst,
   output logic        alusrc,
   output logic [2:0]  memtoreg,
   output logic        regwe,
   output logic        memwe,
   output logic        validbr,
   output logic [2:0]  jump,
   output logic [1:0]  extop,
   output logic [3:0]  aluop,
   output logic        turn
);
   state_t state;
   logic [2:0] cls, d_wbsel, d_jsel, d_brk;
   logic [3:0] d_aluop;
   logic [1:0] d_extop, d_dst;
   logic d_imm, d_wb;
   ctrl_decode u_dec (
      .instr(instr), .cls(cls), .aluop(d_aluop), .extop(d_extop), .imm(d_imm),
      .wb(d_wb), .dst(d_dst), .wbsel(d_wbsel), .jsel(d_jsel), .brk(d_brk)
   );
   always_ff @(posedge clk)
      if (rst) state <= S_FETCH;
      else
         case (state)
            S_FETCH: state <= S_DECODE;
            S_DECODE: state <= cls == C_LOAD || cls == C_STORE ? S_MADDR :
                               cls == C_RTYPE || cls == C_ITYPE ? S_EXEC :
                               cls == C_BRANCH ? S_BRANCH : cls == C_JUMP ? S_JUMP : S_FETCH;
            S_MADDR: state <= cls == C_LOAD ? S_MREAD : S_MWRITE;
            S_MREAD: state <= S_MWB;
            S_EXEC: state <= S_RWB;
            default: state <= S_FETCH;
         endcase
   // reset forces every control low, even though the state register already holds FETCH
   always_comb begin
      PCWr = 1'b0;
      IRWr = 1'b0;
      regdst = RD_RT;
      alusrc = 1'b0;
      memtoreg = M2R_ALU;
      regwe = 1'b0;
      memwe = 1'b0;
      validbr = 1'b0;
      jump = J_SEQ;
      extop = EXT_ZERO;
      aluop = ALU_ADD;
      turn = 1'b0;
      if (!rst)
         case (state)
            S_FETCH: begin PCWr = 1'b1; IRWr = 1'b1; turn = 1'b1; end
            S_MADDR: begin alusrc = 1'b1; extop = EXT_SIGN; end
            S_MWB: begin regwe = 1'b1; memtoreg = M2R_MEM; end
            S_MWRITE: memwe = 1'b1;
            S_EXEC: begin aluop = d_aluop; alusrc = d_imm; extop = d_extop; end
            S_RWB: begin regwe = d_wb; regdst = d_dst; memtoreg = d_wbsel; end
            S_BRANCH: begin PCWr = 1'b1; aluop = ALU_SUB; jump = J_BR; validbr = br_taken(d_brk, compare); end
            S_JUMP: begin
               PCWr = 1'b1;
               jump = d_jsel;
               regwe = d_wb;
               regdst = d_wb ? d_dst : RD_RT;
               memtoreg = d_wb ? d_wbsel : M2R_ALU;
            end
            default: ;
         endcase
   end
endmodule
